spi_adc_reader: RTL and testbench
=================================

SPI_ADC_READER -- requirements
Module: spi_adc_reader

Interface
REQ-001 SHALL have parameter DIV, default 4, giving the SCLK half-period in clk cycles; legal range is DIV >= 2.
REQ-002 SHALL have parameter NBITS, default 16, giving the SCLK cycles per frame.
REQ-003 SHALL have parameter DBITS, default 12, giving the data bits kept per frame; legal range is DBITS <= NBITS.
REQ-004 SHALL have port clk, input, 1 bit: system clock; all logic runs on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port start, input, 1 bit: conversion request, sampled only in IDLE.
REQ-007 SHALL have port miso, input, 1 bit: serial data from the ADC, MSB first.
REQ-008 SHALL have port sclk, output, 1 bit: SPI clock, idles high; registered output.
REQ-009 SHALL have port cs_n, output, 1 bit: ADC chip select, active-low; registered output.
REQ-010 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-011 SHALL have port data_valid, output, 1 bit: one-cycle strobe marking a new data value.
REQ-012 SHALL have port data, output, DBITS bits: last completed sample.

Function
REQ-013 SHALL contain an internal mod-DIV tick counter; the tick asserts when the count equals DIV-1, and the counter clears to 0 on every state change.
REQ-014 SHALL implement the FSM states IDLE, SETUP, LOW, HIGH and QUIET.
REQ-015 IDLE: cs_n=1 and sclk=1; start=1 moves to SETUP on the next edge; otherwise the FSM stays in IDLE.
REQ-016 SETUP: cs_n=0 and sclk=1 for DIV cycles, then moves to LOW.
REQ-017 LOW: sclk=0 for DIV cycles, then moves to HIGH; miso SHALL be shifted into the LSB of an NBITS shift register on the same edge that raises sclk.
REQ-018 HIGH: sclk=1 for DIV cycles; on the tick the bit counter increments, and the FSM moves to LOW if fewer than NBITS bits are done, otherwise to QUIET.
REQ-019 Entry to QUIET SHALL set cs_n=1, load data with the lower DBITS bits of the shift register, and pulse data_valid high for exactly that one cycle.
REQ-020 QUIET: cs_n=1 and sclk=1 for DIV cycles, then moves to IDLE.
REQ-021 Frame timing: cs_n SHALL be low for DIV*(2*NBITS+1) cycles; the time from start acceptance to IDLE SHALL be DIV*(2*NBITS+2) cycles.
REQ-022 The leading NBITS-DBITS received bits SHALL be discarded.
REQ-023 start SHALL be ignored while busy=1; no request is queued.
REQ-024 If start is held high, conversions SHALL run back-to-back with cs_n high for exactly DIV+1 cycles between frames (DIV cycles in QUIET plus 1 in IDLE).
REQ-025 data SHALL hold its value between frames; data_valid SHALL never be high for two consecutive cycles.
REQ-026 The bit counter SHALL be wide enough to hold NBITS without wrap-around.
REQ-027 The tick counter SHALL be wide enough to hold DIV-1.

Reset
REQ-028 While reset=0, all outputs SHALL immediately take these values: sclk=1, cs_n=1, busy=0, data_valid=0, data=0.
REQ-029 While reset=0, the state SHALL be IDLE and all counters and the shift register SHALL be 0.
REQ-030 Reset asserted mid-frame SHALL abort the frame with no data_valid pulse, and data SHALL clear to 0.
REQ-031 After reset deasserts, the first conversion SHALL begin only on a start sampled in IDLE.

Verification
REQ-032 Reset check: assert reset=0 with miso toggling -> sclk=1, cs_n=1, busy=0, data_valid=0 and data=0x000 immediately and throughout reset.
REQ-033 Single frame (DIV=4, NBITS=16, DBITS=12): slave model drives 0x0ABC MSB-first, changing on sclk falling edges; pulse start -> data=0xABC, one data_valid pulse 132 cycles after acceptance, and busy deasserts 136 cycles after acceptance.
REQ-034 Waveform timing, same frame: exactly 16 sclk rising edges occur while cs_n=0; cs_n is low for 132 cycles; each sclk high and low phase lasts 4 cycles.
REQ-035 Busy rejection: pulse start again at bit 5 of a frame -> the frame completes unchanged, only one data_valid pulse occurs, and no second frame starts.
REQ-036 Back-to-back: hold start=1 and drive 0x0FFF then 0x0001 -> data=0xFFF then 0x001, with cs_n high for exactly 5 cycles between the frames.
REQ-037 Abort: assert reset=0 for 3 cycles during bit 7 -> cs_n=1 and sclk=1 immediately, no data_valid pulse, data=0x000, and a following start completes a normal frame.

Source files
------------

// File: rtl/spi_adc_reader.sv
// SPI master that reads one NBITS-long frame from an ADC per start request,
// sampling miso on rising sclk and keeping the lowest DBITS bits received.
module spi_adc_reader #(
  parameter int DIV   = 4,
  parameter int NBITS = 16,
  parameter int DBITS = 12
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             miso,
  output logic             sclk,
  output logic             cs_n,
  output logic             busy,
  output logic             data_valid,
  output logic [DBITS-1:0] data
);

  localparam int CW = $clog2(DIV);
  localparam int BW = $clog2(NBITS + 1);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] SETUP = 3'd1;
  localparam logic [2:0] LOW   = 3'd2;
  localparam logic [2:0] HIGH  = 3'd3;
  localparam logic [2:0] QUIET = 3'd4;

  localparam logic [CW-1:0] TICK_MAX = CW'(DIV - 1);
  localparam logic [BW-1:0] BITS_MAX = BW'(NBITS);

  logic [2:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [BW-1:0]    bits_q, bits_d;
  logic [NBITS-1:0] shift_q, shift_d;
  logic [DBITS-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             sclk_q, sclk_d;
  logic             cs_n_q, cs_n_d;
  logic             tick;

  assign tick = (cnt_q == TICK_MAX);

  always_comb begin
    state_d = state_q;
    bits_d  = bits_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SETUP;
          bits_d  = '0;
        end
      end
      SETUP: begin
        if (tick) state_d = LOW;
      end
      LOW: begin
        // Sample on the same edge that raises sclk; the top bit falls off.
        if (tick) begin
          state_d = HIGH;
          shift_d = NBITS'({shift_q, miso});
        end
      end
      HIGH: begin
        if (tick) begin
          bits_d = bits_q + BW'(1);
          if (bits_d < BITS_MAX) begin
            state_d = LOW;
          end else begin
            state_d = QUIET;
            data_d  = shift_q[DBITS-1:0];
            valid_d = 1'b1;
          end
        end
      end
      QUIET: begin
        if (tick) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // The phase counter restarts with every state so each phase lasts DIV cycles.
  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (state_d != state_q || tick || state_q == IDLE) cnt_d = '0;
  end

  assign sclk_d = (state_d != LOW);
  assign cs_n_d = (state_d == IDLE) || (state_d == QUIET);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bits_q  <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      sclk_q  <= 1'b1;
      cs_n_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bits_q  <= bits_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      sclk_q  <= sclk_d;
      cs_n_q  <= cs_n_d;
    end
  end

  assign sclk       = sclk_q;
  assign cs_n       = cs_n_q;
  assign busy       = (state_q != IDLE);
  assign data_valid = valid_q;
  assign data       = data_q;

endmodule

// File: tb/tb_spi_adc_reader.sv
// Self-checking bench for spi_adc_reader: an ADC slave model plus frame-level
// timing and data expectations derived from the frame arithmetic.
module tb_spi_adc_reader;

  localparam int DIV           = 4;
  localparam int NBITS         = 16;
  localparam int DBITS         = 12;
  localparam int CS_LOW_CYCLES = DIV * (2 * NBITS + 1);
  localparam int FRAME_CYCLES  = DIV * (2 * NBITS + 2);
  localparam int MAX_WAIT      = 3 * FRAME_CYCLES;

  typedef struct {
    logic [NBITS-1:0] word;
    logic [DBITS-1:0] expData;
    int               pokeAt;
  } vector_t;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic             miso;
  logic             sclk;
  logic             csN;
  logic             busy;
  logic             dataValid;
  logic [DBITS-1:0] data;

  logic             toggleMode = 1'b1;
  logic             randMiso = 1'b0;
  logic             slaveMiso = 1'b0;
  logic [NBITS-1:0] slaveQ[$];
  logic [NBITS-1:0] curWord = '0;
  int               bitIdx = 0;

  int total = 0;
  int bad = 0;

  vector_t vectors[8];

  assign miso = toggleMode ? randMiso : slaveMiso;

  spi_adc_reader #(.DIV(DIV), .NBITS(NBITS), .DBITS(DBITS)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .miso      (miso),
    .sclk      (sclk),
    .cs_n      (csN),
    .busy      (busy),
    .data_valid(dataValid),
    .data      (data)
  );

  always #5 clk = ~clk;

  // ADC slave: loads the next queued word on chip select and presents one
  // bit per falling sclk, MSB first.
  always @(negedge csN) begin
    if (slaveQ.size() > 0) curWord = slaveQ.pop_front();
    else curWord = '0;
    bitIdx = NBITS;
  end

  always @(negedge sclk) begin
    if (!csN && bitIdx > 0) begin
      bitIdx = bitIdx - 1;
      slaveMiso = curWord[bitIdx];
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  // Runs one frame from IDLE and measures it sample by sample on the falling
  // clock; sample k is taken k cycles after the accepting edge.
  task automatic applyStimulus(input logic [NBITS-1:0] w, input logic [DBITS-1:0] expData,
                               input int pokeAt);
    int k, validCount, validAt, busyLowAt, csLow, rises, phaseErr, run;
    logic prevSclk;
    logic [DBITS-1:0] captured;
    slaveQ.push_back(w);
    k = 0; validCount = 0; validAt = -1; busyLowAt = -1;
    csLow = 0; rises = 0; phaseErr = 0; run = 0;
    prevSclk = 1'b1; captured = '0;
    start = 1'b1;
    @(negedge clk);
    checkOutput("accept", {31'd0, busy}, 32'd1);
    while (busyLowAt < 0 && k < MAX_WAIT) begin
      if (dataValid) begin
        validCount++;
        if (validAt < 0) begin
          validAt = k;
          captured = data;
        end
      end
      if (!csN) begin
        csLow++;
        if (sclk == prevSclk) run++;
        else begin
          if (run != DIV) phaseErr++;
          if (sclk) rises++;
          run = 1;
        end
      end
      prevSclk = sclk;
      if (!busy) busyLowAt = k;
      start = (k == pokeAt);
      @(negedge clk);
      k++;
    end
    start = 1'b0;
    checkOutput("frameData", {20'd0, captured}, {20'd0, expData});
    checkOutput("validCount", validCount, 1);
    checkOutput("validLatency", validAt, CS_LOW_CYCLES);
    checkOutput("busyLatency", busyLowAt, FRAME_CYCLES);
    checkOutput("csLowCycles", csLow, CS_LOW_CYCLES);
    checkOutput("sclkRises", rises, NBITS);
    checkOutput("phaseLength", phaseErr, 0);
    repeat (3) @(negedge clk);
    checkOutput("dataHeld", {20'd0, data}, {20'd0, expData});
    checkOutput("noRequeue", {30'd0, busy, ~csN}, 32'd0);
  endtask

  initial begin
    int k, phase, gap;
    logic [DBITS-1:0] got[$];

    vectors[0] = '{16'h0ABC, 12'hABC, -1};
    vectors[1] = '{16'hFFFF, 12'hFFF, -1};
    vectors[2] = '{16'hF000, 12'h000, -1};
    vectors[3] = '{16'h5A5A, 12'hA5A, 4 + 8 * 5};
    for (int i = 4; i < 8; i++) begin
      vectors[i].word    = NBITS'($urandom);
      vectors[i].expData = DBITS'(vectors[i].word % (1 << DBITS));
      vectors[i].pokeAt  = -1;
    end

    // Reset with miso and start wiggling: outputs must be idle at once.
    #2 reset = 1'b0;
    #1;
    checkOutput("rstImmSclk", {31'd0, sclk}, 32'd1);
    checkOutput("rstImmCs", {31'd0, csN}, 32'd1);
    checkOutput("rstImmData", {20'd0, data}, 32'd0);
    for (int i = 0; i < 6; i++) begin
      randMiso = 1'($urandom_range(0, 1));
      start = 1'($urandom_range(0, 1));
      @(negedge clk);
      checkOutput("rstSclk", {31'd0, sclk}, 32'd1);
      checkOutput("rstCs", {31'd0, csN}, 32'd1);
      checkOutput("rstBusy", {31'd0, busy}, 32'd0);
      checkOutput("rstValid", {31'd0, dataValid}, 32'd0);
      checkOutput("rstData", {20'd0, data}, 32'd0);
    end
    start = 1'b0;
    reset = 1'b1;
    toggleMode = 1'b0;
    repeat (5) @(negedge clk);
    checkOutput("idleNoStart", {30'd0, busy, ~csN}, 32'd0);

    for (int i = 0; i < 8; i++)
      applyStimulus(vectors[i].word, vectors[i].expData, vectors[i].pokeAt);

    // Back-to-back frames with start held high.
    slaveQ.push_back(16'h0FFF);
    slaveQ.push_back(16'h0001);
    got.delete();
    phase = 0; gap = 0; k = 0;
    start = 1'b1;
    while (got.size() < 2 && k < MAX_WAIT) begin
      @(negedge clk);
      k++;
      if (dataValid) begin
        got.push_back(data);
        if (got.size() == 2) start = 1'b0;
      end
      if (phase == 0 && !csN) phase = 1;
      else if (phase == 1 && csN) begin
        phase = 2;
        gap = 1;
      end else if (phase == 2) begin
        if (csN) gap++;
        else phase = 3;
      end
    end
    start = 1'b0;
    checkOutput("b2bCount", got.size(), 2);
    checkOutput("b2bData0", {20'd0, got[0]}, 32'h0FFF);
    checkOutput("b2bData1", {20'd0, got[1]}, 32'h0001);
    checkOutput("b2bGap", gap, DIV + 1);
    k = 0;
    while (busy && k < FRAME_CYCLES) begin
      @(negedge clk);
      k++;
    end
    repeat (3) @(negedge clk);
    checkOutput("b2bStops", {30'd0, busy, ~csN}, 32'd0);

    // Abort during bit 7.
    slaveQ.push_back(16'h0ABC);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4 + 8 * 7 + 1) @(negedge clk);
    checkOutput("preAbortBusy", {31'd0, busy}, 32'd1);
    reset = 1'b0;
    #1;
    checkOutput("abortCs", {31'd0, csN}, 32'd1);
    checkOutput("abortSclk", {31'd0, sclk}, 32'd1);
    checkOutput("abortBusy", {31'd0, busy}, 32'd0);
    checkOutput("abortData", {20'd0, data}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("abortValid", {31'd0, dataValid}, 32'd0);
      checkOutput("abortHold", {30'd0, csN, sclk}, 32'd3);
    end
    reset = 1'b1;
    @(negedge clk);
    checkOutput("postAbortValid", {31'd0, dataValid}, 32'd0);
    applyStimulus(16'h0321, 12'h321, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
